// File: rtl/fifo_param.sv
// Parameterised single-clock FIFO with live thresholds and a sticky error flag.
// Define FIFO_FWFT_EN for first-word-fall-through output; default is registered pop.
module fifo_param #(
    parameter int BW    = 4,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset_L,
    input  logic          fifo_wr,
    input  logic          fifo_rd,
    input  logic [BW-1:0] fifo_data_in,
    input  logic [AW:0]   af_th,
    input  logic [AW:0]   ae_th,
    output logic [BW-1:0] fifo_data_out,
    output logic          fifo_valid,
    output logic          fifo_full,
    output logic          fifo_empty,
    output logic          fifo_almost_full,
    output logic          fifo_almost_empty,
    output logic [AW:0]   fifo_count,
    output logic          error_output
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [BW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          err_q, err_d;
    logic          rd_ok, wr_ok;

    assign fifo_full         = (count_q == FULL_CNT);
    assign fifo_empty        = (count_q == '0);
    assign fifo_almost_full  = (count_q >= af_th);
    assign fifo_almost_empty = (count_q <= ae_th);
    assign fifo_count        = count_q;
    assign error_output      = err_q;

    // A full FIFO still takes a write when a read frees a slot this cycle.
    assign rd_ok = fifo_rd & ~fifo_empty;
    assign wr_ok = fifo_wr & (~fifo_full | rd_ok);

    // Next-state for pointers, occupancy and the sticky error.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
        if (wr_ok && !rd_ok) begin
            count_d = count_q + 1'b1;
        end else if (rd_ok && !wr_ok) begin
            count_d = count_q - 1'b1;
        end
        err_d = err_q
              | (fifo_wr & fifo_full & ~rd_ok)
              | (fifo_rd & fifo_empty);
    end

    // Control state; reset discards contents by clearing pointers and count.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

    // Storage array is not reset; only accepted writes touch it.
    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wr_ptr_q] <= fifo_data_in;
    end

`ifdef FIFO_FWFT_EN
    assign fifo_data_out = mem_q[rd_ptr_q];
    assign fifo_valid    = ~fifo_empty;
`else
    logic [BW-1:0] dout_q, dout_d;
    logic          valid_q;

    assign dout_d        = rd_ok ? mem_q[rd_ptr_q] : dout_q;
    assign fifo_data_out = dout_q;
    assign fifo_valid    = valid_q;

    // Popped word is captured at the read edge; valid pulses for that cycle.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            dout_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            dout_q  <= dout_d;
            valid_q <= rd_ok;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_param.sv
// Self-checking bench for fifo_param (standard mode, BW=4, DEPTH=8).
// Directed scenarios plus random traffic against a queue model.
module tb_fifo_param;

    localparam int BW    = 4;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          clk;
    logic          reset_L;
    logic          fifo_wr;
    logic          fifo_rd;
    logic [BW-1:0] fifo_data_in;
    logic [AW:0]   af_th;
    logic [AW:0]   ae_th;
    logic [BW-1:0] fifo_data_out;
    logic          fifo_valid;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_almost_full;
    logic          fifo_almost_empty;
    logic [AW:0]   fifo_count;
    logic          error_output;

    int total = 0;
    int bad   = 0;

    logic [BW-1:0] q[$];
    logic [BW-1:0] m_dout;
    bit            m_valid;
    bit            m_err;

    fifo_param #(.BW(BW), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk              (clk),
        .reset_L          (reset_L),
        .fifo_wr          (fifo_wr),
        .fifo_rd          (fifo_rd),
        .fifo_data_in     (fifo_data_in),
        .af_th            (af_th),
        .ae_th            (ae_th),
        .fifo_data_out    (fifo_data_out),
        .fifo_valid       (fifo_valid),
        .fifo_full        (fifo_full),
        .fifo_empty       (fifo_empty),
        .fifo_almost_full (fifo_almost_full),
        .fifo_almost_empty(fifo_almost_empty),
        .fifo_count       (fifo_count),
        .error_output     (error_output)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock with the given request; model follows the FIFO rules.
    task automatic cycle(input bit wr, input bit rd, input logic [BW-1:0] d);
        bit m_empty, m_full, rok, wok;
        fifo_wr      = wr;
        fifo_rd      = rd;
        fifo_data_in = d;
        @(posedge clk);
        m_empty = (q.size() == 0);
        m_full  = (q.size() == DEPTH);
        rok = rd && !m_empty;
        wok = wr && (!m_full || rok);
        if ((wr && m_full && !rok) || (rd && m_empty)) m_err = 1'b1;
        m_valid = rok;
        if (rok) m_dout = q.pop_front();
        if (wok) q.push_back(d);
        #1;
        fifo_wr = 1'b0;
        fifo_rd = 1'b0;
    endtask

    task automatic do_reset();
        fifo_wr = 1'b0;
        fifo_rd = 1'b0;
        #2;
        reset_L = 1'b0;
        q.delete();
        m_dout  = '0;
        m_valid = 1'b0;
        m_err   = 1'b0;
        #1;
        @(negedge clk);
        reset_L = 1'b1;
    endtask

    task automatic test_reset();
        af_th = 4'd6;
        ae_th = 4'd2;
        do_reset();
        total++;
        if (fifo_count !== 4'd0 || fifo_empty !== 1'b1 ||
            fifo_full !== 1'b0 || error_output !== 1'b0 ||
            fifo_valid !== 1'b0 || fifo_data_out !== 4'h0) begin
            bad++;
            $display("FAIL reset: cnt=%0d e=%b f=%b err=%b v=%b d=%h",
                     fifo_count, fifo_empty, fifo_full, error_output,
                     fifo_valid, fifo_data_out);
        end
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 1; i <= 7; i++) begin
            cycle(1'b1, 1'b0, BW'(i));
            total++;
            if (fifo_count !== 4'(i) || fifo_full !== 1'b0 ||
                fifo_almost_full !== (i >= 6) ||
                fifo_almost_empty !== (i <= 2)) begin
                bad++;
                $display("FAIL fill%0d: cnt=%0d f=%b af=%b ae=%b",
                         i, fifo_count, fifo_full,
                         fifo_almost_full, fifo_almost_empty);
            end
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 1; i <= 8; i++) cycle(1'b1, 1'b0, BW'(i));
        total++;
        if (fifo_full !== 1'b1 || error_output !== 1'b0) begin
            bad++;
            $display("FAIL ovf_full: f=%b err=%b want 1 0",
                     fifo_full, error_output);
        end
        cycle(1'b1, 1'b0, 4'd9);
        total++;
        if (error_output !== 1'b1 || fifo_count !== 4'd8) begin
            bad++;
            $display("FAIL ovf_err: err=%b cnt=%0d want 1 8",
                     error_output, fifo_count);
        end
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b0, 1'b1, 4'h0);
            total++;
            if (fifo_data_out !== BW'(i) || fifo_valid !== 1'b1 ||
                error_output !== 1'b1) begin
                bad++;
                $display("FAIL ovf_rd%0d: d=%h v=%b err=%b want %h 1 1",
                         i, fifo_data_out, fifo_valid, error_output,
                         BW'(i));
            end
        end
        total++;
        if (fifo_empty !== 1'b1) begin
            bad++;
            $display("FAIL ovf_empty: e=%b want 1", fifo_empty);
        end
    endtask

    task automatic test_full_rw();
        logic [BW-1:0] exp;
        do_reset();
        for (int i = 1; i <= 8; i++) cycle(1'b1, 1'b0, BW'(i));
        for (int i = 1; i <= 4; i++) begin
            cycle(1'b1, 1'b1, 4'hA);
            total++;
            if (fifo_count !== 4'd8 || fifo_data_out !== BW'(i) ||
                error_output !== 1'b0) begin
                bad++;
                $display("FAIL fullrw%0d: cnt=%0d d=%h err=%b want 8 %h 0",
                         i, fifo_count, fifo_data_out, error_output,
                         BW'(i));
            end
        end
        for (int i = 0; i < 8; i++) begin
            exp = (i < 4) ? BW'(i + 5) : 4'hA;
            cycle(1'b0, 1'b1, 4'h0);
            total++;
            if (fifo_data_out !== exp) begin
                bad++;
                $display("FAIL fullrw_drain%0d: d=%h want %h",
                         i, fifo_data_out, exp);
            end
        end
    endtask

    task automatic test_underflow();
        do_reset();
        cycle(1'b0, 1'b1, 4'h0);
        total++;
        if (fifo_valid !== 1'b0 || error_output !== 1'b1 ||
            fifo_count !== 4'd0) begin
            bad++;
            $display("FAIL udf: v=%b err=%b cnt=%0d want 0 1 0",
                     fifo_valid, error_output, fifo_count);
        end
    endtask

    task automatic test_latency();
        do_reset();
        cycle(1'b1, 1'b0, 4'h3);
        total++;
        if (fifo_valid !== 1'b0) begin
            bad++;
            $display("FAIL lat_pre: v=%b want 0", fifo_valid);
        end
        cycle(1'b0, 1'b1, 4'h0);
        total++;
        if (fifo_data_out !== 4'h3 || fifo_valid !== 1'b1) begin
            bad++;
            $display("FAIL lat_pop: d=%h v=%b want 3 1",
                     fifo_data_out, fifo_valid);
        end
        cycle(1'b0, 1'b0, 4'h0);
        total++;
        if (fifo_data_out !== 4'h3 || fifo_valid !== 1'b0) begin
            bad++;
            $display("FAIL lat_hold: d=%h v=%b want 3 0",
                     fifo_data_out, fifo_valid);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        cycle(1'b0, 1'b1, 4'h0);
        for (int i = 1; i <= 5; i++) cycle(1'b1, 1'b0, BW'(i + 10));
        #2;
        reset_L = 1'b0;
        q.delete();
        m_dout  = '0;
        m_valid = 1'b0;
        m_err   = 1'b0;
        #1;
        total++;
        if (fifo_count !== 4'd0 || fifo_empty !== 1'b1 ||
            error_output !== 1'b0) begin
            bad++;
            $display("FAIL midrst: cnt=%0d e=%b err=%b want 0 1 0",
                     fifo_count, fifo_empty, error_output);
        end
        @(negedge clk);
        reset_L = 1'b1;
        cycle(1'b1, 1'b0, 4'hC);
        cycle(1'b0, 1'b1, 4'h0);
        total++;
        if (fifo_data_out !== 4'hC || fifo_valid !== 1'b1) begin
            bad++;
            $display("FAIL midrst_rd: d=%h v=%b want c 1",
                     fifo_data_out, fifo_valid);
        end
    endtask

    task automatic test_random();
        int wp, rp, n;
        bit wr, rd;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if (i % 50 == 0) begin
                af_th = 4'($urandom_range(0, DEPTH));
                ae_th = 4'($urandom_range(0, DEPTH));
            end
            wp = ((i / 100) % 2 == 0) ? 70 : 35;
            rp = ((i / 100) % 2 == 0) ? 35 : 70;
            wr = ($urandom_range(0, 99) < wp);
            rd = ($urandom_range(0, 99) < rp);
            cycle(wr, rd, 4'($urandom));
            n = q.size();
            total++;
            if (fifo_count !== 4'(n) ||
                fifo_full !== (n == DEPTH) ||
                fifo_empty !== (n == 0) ||
                fifo_almost_full !== (n >= int'(af_th)) ||
                fifo_almost_empty !== (n <= int'(ae_th)) ||
                fifo_valid !== m_valid ||
                fifo_data_out !== m_dout ||
                error_output !== m_err) begin
                bad++;
                $display("FAIL rand%0d: cnt=%0d/%0d d=%h/%h v=%b/%b err=%b/%b f=%b e=%b af=%b ae=%b",
                         i, fifo_count, n, fifo_data_out, m_dout,
                         fifo_valid, m_valid, error_output, m_err,
                         fifo_full, fifo_empty,
                         fifo_almost_full, fifo_almost_empty);
            end
        end
    endtask

    initial begin
        reset_L      = 1'b1;
        fifo_wr      = 1'b0;
        fifo_rd      = 1'b0;
        fifo_data_in = '0;
        af_th        = 4'd6;
        ae_th        = 4'd2;
        m_dout       = '0;
        m_valid      = 1'b0;
        m_err        = 1'b0;
        @(negedge clk);
        test_reset();
        test_fill();
        test_overflow();
        test_full_rw();
        test_underflow();
        test_latency();
        test_reset_mid();
        af_th = 4'd6;
        ae_th = 4'd2;
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
